// File: rtl/fir_result_tx.sv
// fir_result_tx
// Transmit-side companion to the FIR core output. 16-bit results strobed out
// of the core are queued in a small FIFO and sent over an 8-bit bus as two
// byte beats (low, then high) under a valid/ready handshake.
//
// Build option: define FIR_TX_CKSUM_EN to append a third beat per word
// carrying low^high, flagged by tx_ck=1 (tx_hi stays 1 on that beat).
//
// Ports:
//   clk        system clock, all state on rising edge
//   rst        asynchronous active-high reset
//   y_dat      result word from the FIR core
//   y_vld      one-cycle strobe, y_dat valid this cycle
//   tx_byte    byte currently offered (registered)
//   tx_vld     tx_byte valid (registered)
//   tx_rdy     downstream accepts the byte when tx_vld & tx_rdy
//   tx_hi      0 = low-byte beat, 1 = high-byte (or checksum) beat
//   fifo_level words held in the FIFO, excluding the word in transmission
//   overflow   sticky: a result was dropped because the FIFO was full
//   tx_ck      (FIR_TX_CKSUM_EN only) 1 on the checksum beat
module fir_result_tx #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] y_dat,
  input  logic              y_vld,
  output logic [7:0]        tx_byte,
  output logic              tx_vld,
  input  logic              tx_rdy,
  output logic              tx_hi,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              overflow
`ifdef FIR_TX_CKSUM_EN
  ,
  output logic              tx_ck
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    CK   = 2'd3
  } state_t;

`ifdef FIR_TX_CKSUM_EN
  // Checksum beat: bytewise XOR of the held word.
  function automatic logic [7:0] cksum_byte(input logic [DATA_W-1:0] w);
    return w[7:0] ^ w[15:8];
  endfunction
`endif

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [LVL_W-1:0]  level_r;
  logic [DATA_W-1:0] hold_r;
  state_t            state_r;

  logic              full_s;
  logic              has_word_s;
  logic              push_s;
  logic              pop_s;
  logic              word_done_s;
  logic [DATA_W-1:0] head_s;

  // Fullness is judged on the pre-edge count, so a same-edge pop never
  // rescues a write into a full FIFO.
  assign full_s     = (level_r == LVL_W'(DEPTH));
  assign has_word_s = (level_r != {LVL_W{1'b0}});
  assign push_s     = y_vld & ~full_s;
  assign head_s     = mem_r[rd_ptr_r];
  assign fifo_level = level_r;

  // Decide whether the current word finishes this edge and whether to pop.
  always_comb begin
    word_done_s = 1'b0;
    case (state_r)
`ifdef FIR_TX_CKSUM_EN
      CK:      word_done_s = tx_rdy;
`else
      HI:      word_done_s = tx_rdy;
`endif
      default: word_done_s = 1'b0;
    endcase
    pop_s = ((state_r == IDLE) | word_done_s) & has_word_s;
  end

  // FIFO storage; contents need no reset since level_r gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= y_dat;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
      overflow <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LVL_W'(1);
        2'b01:   level_r <= level_r - LVL_W'(1);
        default: level_r <= level_r;
      endcase
      if (y_vld && full_s) begin
        overflow <= 1'b1;
      end
    end
  end

  // Beat sequencer with registered outputs; a pop loads the next word and
  // presents its low byte on the same edge, so words go back to back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      hold_r  <= {DATA_W{1'b0}};
      tx_vld  <= 1'b0;
      tx_byte <= 8'h00;
      tx_hi   <= 1'b0;
`ifdef FIR_TX_CKSUM_EN
      tx_ck   <= 1'b0;
`endif
    end else if (pop_s) begin
      state_r <= LO;
      hold_r  <= head_s;
      tx_vld  <= 1'b1;
      tx_byte <= head_s[7:0];
      tx_hi   <= 1'b0;
`ifdef FIR_TX_CKSUM_EN
      tx_ck   <= 1'b0;
`endif
    end else if (word_done_s) begin
      state_r <= IDLE;
      tx_vld  <= 1'b0;
      tx_byte <= 8'h00;
      tx_hi   <= 1'b0;
`ifdef FIR_TX_CKSUM_EN
      tx_ck   <= 1'b0;
`endif
    end else begin
      case (state_r)
        LO: begin
          if (tx_rdy) begin
            state_r <= HI;
            tx_byte <= hold_r[15:8];
            tx_hi   <= 1'b1;
          end
        end
`ifdef FIR_TX_CKSUM_EN
        HI: begin
          if (tx_rdy) begin
            state_r <= CK;
            tx_byte <= cksum_byte(hold_r);
            tx_ck   <= 1'b1;
          end
        end
`endif
        default: state_r <= state_r;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_result_tx.sv
// Self-checking bench for fir_result_tx: stimulus pushes expected beats into
// a queue, a negedge monitor pops and compares on every handshake.
module tb_fir_result_tx;

`ifdef FIR_TX_CKSUM_EN
  localparam int BEATS = 3;
`else
  localparam int BEATS = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] y_dat = 16'h0000;
  logic        y_vld = 1'b0;
  logic        tx_rdy = 1'b0;
  logic [7:0]  tx_byte;
  logic        tx_vld;
  logic        tx_hi;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic        mon_ck;
`ifdef FIR_TX_CKSUM_EN
  logic        tx_ck;
  assign mon_ck = tx_ck;
`else
  assign mon_ck = 1'b0;
`endif

  int tests = 0;
  int fails = 0;
  logic [9:0] exp_q[$];   // {ck, hi, byte}
  logic [9:0] mon_exp;

  fir_result_tx dut (
    .clk        (clk),
    .rst        (rst),
    .y_dat      (y_dat),
    .y_vld      (y_vld),
    .tx_byte    (tx_byte),
    .tx_vld     (tx_vld),
    .tx_rdy     (tx_rdy),
    .tx_hi      (tx_hi),
    .fifo_level (fifo_level),
    .overflow   (overflow)
`ifdef FIR_TX_CKSUM_EN
    ,
    .tx_ck      (tx_ck)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input logic [15:0] w);
    exp_q.push_back({2'b00, w[7:0]});
    exp_q.push_back({2'b01, w[15:8]});
`ifdef FIR_TX_CKSUM_EN
    exp_q.push_back({2'b11, w[7:0] ^ w[15:8]});
`endif
  endtask

  task automatic strobe(input logic [15:0] w);
    y_dat = w;
    y_vld = 1'b1;
    tick;
    y_vld = 1'b0;
  endtask

  task automatic drain;
    int n;
    n = 0;
    tx_rdy = 1'b1;
    while ((tx_vld || fifo_level != 3'd0 || exp_q.size() != 0) && n < 200) begin
      tick;
      n++;
    end
    tests++;
    if (n >= 200) begin
      fails++;
      $display("FAIL drain: timed out with %0d beats still expected", exp_q.size());
    end
  endtask

  // Monitor: every accepted beat must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && tx_vld && tx_rdy) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL beat: unexpected beat 0x%0h with nothing expected", tx_byte);
      end else begin
        mon_exp = exp_q.pop_front();
        check("beat", {6'b0, mon_ck, tx_hi, tx_byte}, {6'b0, mon_exp});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick;
    tick;
    check("rst_vld", tx_vld, 16'd0);
    check("rst_byte", tx_byte, 16'h00);
    check("rst_hi", tx_hi, 16'd0);
    check("rst_level", fifo_level, 16'd0);
    check("rst_ovf", overflow, 16'd0);
    rst = 1'b0;
    tick;

    // Single word, free-flowing downstream: low byte two cycles after strobe
    tx_rdy = 1'b1;
    expect_word(16'h1234);
    strobe(16'h1234);
    check("t1_c1_vld", tx_vld, 16'd0);
    tick;
    check("t1_c2_vld", tx_vld, 16'd1);
    check("t1_c2_byte", tx_byte, 16'h34);
    check("t1_c2_hi", tx_hi, 16'd0);
    tick;
    check("t1_c3_vld", tx_vld, 16'd1);
    check("t1_c3_byte", tx_byte, 16'h12);
    check("t1_c3_hi", tx_hi, 16'd1);
    tick;
`ifdef FIR_TX_CKSUM_EN
    check("t1_ck_vld", tx_vld, 16'd1);
    check("t1_ck_byte", tx_byte, 16'h26);
    check("t1_ck_flag", tx_ck, 16'd1);
    check("t1_ck_hi", tx_hi, 16'd1);
    tick;
`endif
    check("t1_end_vld", tx_vld, 16'd0);
    check("t1_ovf", overflow, 16'd0);

    // Backpressure: low byte held for 5 cycles, high byte after tx_rdy rises
    tx_rdy = 1'b0;
    expect_word(16'h1234);
    strobe(16'h1234);
    tick;
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_vld", tx_vld, 16'd1);
      check("t2_hold_byte", tx_byte, 16'h34);
      check("t2_hold_hi", tx_hi, 16'd0);
      tick;
    end
    tx_rdy = 1'b1;
    check("t2_rise_byte", tx_byte, 16'h34);
    tick;
    check("t2_hi_byte", tx_byte, 16'h12);
    check("t2_hi_flag", tx_hi, 16'd1);
    drain;

    // Fill and overflow: one word in transmission, four queued, sixth dropped
    tx_rdy = 1'b0;
    for (int v = 1; v <= 6; v++) begin
      y_dat = 16'(v);
      y_vld = 1'b1;
      if (v <= 5) expect_word(16'(v));
      tick;
    end
    y_vld = 1'b0;
    check("t3_level", fifo_level, 16'd4);
    check("t3_ovf", overflow, 16'd1);
    check("t3_vld", tx_vld, 16'd1);
    check("t3_byte", tx_byte, 16'h01);
    tx_rdy = 1'b1;
    for (int i = 0; i < 5 * BEATS; i++) begin
      check("t3_nogap", tx_vld, 16'd1);
      tick;
    end
    check("t3_end_vld", tx_vld, 16'd0);
    check("t3_left", 16'(exp_q.size()), 16'd0);
    check("t3_ovf_sticky", overflow, 16'd1);

    // Write coinciding with the end-of-word pop: level unchanged, order kept
    tx_rdy = 1'b0;
    expect_word(16'hA1A2);
    expect_word(16'hB1B2);
    expect_word(16'hC1C2);
    expect_word(16'hD1D2);
    strobe(16'hA1A2);
    strobe(16'hB1B2);
    strobe(16'hC1C2);
    check("t4_level_pre", fifo_level, 16'd2);
    tx_rdy = 1'b1;
    tick;
`ifdef FIR_TX_CKSUM_EN
    tick;
`endif
    y_dat = 16'hD1D2;
    y_vld = 1'b1;
    tick;
    y_vld = 1'b0;
    tx_rdy = 1'b0;
    check("t4_level_post", fifo_level, 16'd2);
    check("t4_next_byte", tx_byte, 16'hB2);
    check("t4_next_hi", tx_hi, 16'd0);
    drain;

    // Reset in the middle of a word, with another word queued behind it
    tx_rdy = 1'b0;
    expect_word(16'hABCD);
    strobe(16'hABCD);
    tick;
    tx_rdy = 1'b1;
    y_dat = 16'h7777;
    y_vld = 1'b1;
    tick;
    y_vld = 1'b0;
    tx_rdy = 1'b0;
    check("t5_hi_byte", tx_byte, 16'hAB);
    check("t5_level_pre", fifo_level, 16'd1);
    rst = 1'b1;
    #1;
    check("t5_rst_vld", tx_vld, 16'd0);
    check("t5_rst_level", fifo_level, 16'd0);
    exp_q.delete();
    tick;
    rst = 1'b0;
    tick;
    tx_rdy = 1'b1;
    expect_word(16'h5566);
    strobe(16'h5566);
    tick;
    check("t5_new_lo", tx_byte, 16'h66);
    tick;
    check("t5_new_hi", tx_byte, 16'h55);
    check("t5_new_hi_flag", tx_hi, 16'd1);
    drain;

    check("final_queue", 16'(exp_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
